spi_register_controller: RTL and testbench

- Configuration front end for the synth top level: an SPI slave that collects serial frames and buffers them in a small FIFO.
- Replays each frame as a single-cycle register write (enable, 16-bit number, 8-bit value) into the synth register-write port.
- Replaces direct parallel register writes; all logic runs in the i_Clock domain.
- SPI pins are oversampled; no SPI-clocked flops.

---
 rtl/spi_register_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_spi_register_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_register_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_register_controller                                       |
// | Purpose  : Oversampled SPI (mode 0) slave that collects 24-bit frames    |
// |            {number[15:8], number[7:0], value[7:0]}, buffers them in a    |
// |            FIFO and replays each one as a single-cycle register write.   |
// |            Optional feature macro: SPI_AUTO_INCREMENT_EN (when defined,  |
// |            every further data byte in a frame is written to the next     |
// |            register number).                                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module spi_register_controller #(
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          i_Clock,
   input  logic                          i_Reset,
   input  logic                          i_SpiSck,
   input  logic                          i_SpiCsN,
   input  logic                          i_SpiMosi,
   output logic                          o_SpiMiso,
   input  logic                          i_WriteStall,
   output logic                          o_RegisterWriteEnable,
   output logic [15:0]                   o_RegisterWriteNumber,
   output logic [7:0]                    o_RegisterWriteValue,
   output logic [$clog2(FIFO_DEPTH):0]   o_FifoLevel,
   output logic                          o_Overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] c_LEVEL_FULL = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0] c_LEVEL_ONE  = LVL_W'(1);
   localparam logic [PTR_W-1:0] c_PTR_ONE    = PTR_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR_HI = 3'd1,
      ST_ADDR_LO = 3'd2,
      ST_DATA    = 3'd3,
      ST_IGNORE  = 3'd4
   } state_t;

   // ---------------------------------------------------------------------
   // Pin synchronisers and edge detection
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sck_prev;
   logic                   r_cs_prev;
   logic                   w_sck;
   logic                   w_cs_n;
   logic                   w_mosi;
   logic                   w_sck_rise;
   logic                   w_sck_fall;
   logic                   w_cs_fall;

   // Bring the SPI pins into the i_Clock domain and keep the previous sample
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_sck_sync  <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sck_prev  <= 1'b0;
         r_cs_prev   <= 1'b1;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_SpiSck};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_SpiCsN};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_SpiMosi};
         r_sck_prev  <= w_sck;
         r_cs_prev   <= w_cs_n;
      end
   end

   assign w_sck      = r_sck_sync[SYNC_STAGES-1];
   assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
   assign w_sck_rise = !r_sck_prev && w_sck;
   assign w_sck_fall = r_sck_prev && !w_sck;
   assign w_cs_fall  = r_cs_prev && !w_cs_n;

   // ---------------------------------------------------------------------
   // Frame state machine
   // ---------------------------------------------------------------------
   state_t      r_state;
   logic [2:0]  r_bit_cnt;
   logic [6:0]  r_shift;
   logic [15:0] r_number;
   logic [6:0]  r_miso_shift;
   logic [7:0]  w_byte;
   logic [7:0]  w_status;
   logic        w_byte_done;
   logic        w_push;
   logic [23:0] w_push_data;
   logic        w_full;
   logic        w_empty;

   // The completed byte includes the bit arriving on the current rise
   assign w_byte      = {r_shift, w_mosi};
   assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);
   assign w_push      = !w_cs_n && (r_state == ST_DATA) && w_byte_done;
   assign w_push_data = {r_number, w_byte};
   assign w_status    = {o_Overflow, w_full, w_empty, 5'b00000};

   // Deserialise frames and shift the status byte out on MISO
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_state      <= ST_IDLE;
         r_bit_cnt    <= 3'd0;
         r_shift      <= 7'd0;
         r_number     <= 16'd0;
         r_miso_shift <= 7'd0;
         o_SpiMiso    <= 1'b0;
      end else if (w_cs_n) begin
         // Deselect abandons any partial frame or byte
         r_state   <= ST_IDLE;
         r_bit_cnt <= 3'd0;
         o_SpiMiso <= 1'b0;
      end else begin
         if ((r_state != ST_IDLE) && (r_state != ST_IGNORE) && w_sck_rise) begin
            r_shift   <= {r_shift[5:0], w_mosi};
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_cs_fall) begin
                  r_state      <= ST_ADDR_HI;
                  r_bit_cnt    <= 3'd0;
                  o_SpiMiso    <= w_status[7];
                  r_miso_shift <= w_status[6:0];
               end
            end
            ST_ADDR_HI: begin
               if (w_byte_done) begin
                  r_number[15:8] <= w_byte;
                  r_state        <= ST_ADDR_LO;
                  o_SpiMiso      <= 1'b0;
               end else if (w_sck_fall) begin
                  o_SpiMiso    <= r_miso_shift[6];
                  r_miso_shift <= {r_miso_shift[5:0], 1'b0};
               end
            end
            ST_ADDR_LO: begin
               if (w_byte_done) begin
                  r_number[7:0] <= w_byte;
                  r_state       <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_byte_done) begin
`ifdef SPI_AUTO_INCREMENT_EN
                  r_number <= r_number + 16'd1;
`else
                  r_state <= ST_IGNORE;
`endif
               end
            end
            ST_IGNORE: begin
               r_state <= ST_IGNORE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Write FIFO with registered output port
   // ---------------------------------------------------------------------
   logic [23:0]      r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic             w_pop;
   logic             w_push_ok;

   assign w_full    = (o_FifoLevel == c_LEVEL_FULL);
   assign w_empty   = (o_FifoLevel == '0);
   assign w_pop     = !w_empty && !i_WriteStall;
   // A full FIFO still accepts a push when an entry leaves in the same cycle
   assign w_push_ok = w_push && (!w_full || w_pop);

   // Storage needs no reset: the pointers define which entries are valid
   always_ff @(posedge i_Clock) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= w_push_data;
      end
   end

   // Pointer, occupancy, overflow and write-port bookkeeping
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_wr_ptr              <= '0;
         r_rd_ptr              <= '0;
         o_FifoLevel           <= '0;
         o_Overflow            <= 1'b0;
         o_RegisterWriteEnable <= 1'b0;
         o_RegisterWriteNumber <= 16'd0;
         o_RegisterWriteValue  <= 8'd0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_push && !w_push_ok) begin
            o_Overflow <= 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr              <= r_rd_ptr + c_PTR_ONE;
            o_RegisterWriteEnable <= 1'b1;
            o_RegisterWriteNumber <= r_mem[r_rd_ptr][23:8];
            o_RegisterWriteValue  <= r_mem[r_rd_ptr][7:0];
         end else begin
            o_RegisterWriteEnable <= 1'b0;
         end
         case ({w_push_ok, w_pop})
            2'b10:   o_FifoLevel <= o_FifoLevel + c_LEVEL_ONE;
            2'b01:   o_FifoLevel <= o_FifoLevel - c_LEVEL_ONE;
            default: o_FifoLevel <= o_FifoLevel;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_register_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_spi_register_controller                                    |
// | Purpose  : Directed self-checking bench for spi_register_controller.     |
// |            Honours SPI_AUTO_INCREMENT_EN when selecting expectations.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_spi_register_controller;

   logic        clk;
   logic        rst;
   logic        sck;
   logic        cs_n;
   logic        mosi;
   logic        miso;
   logic        stall;
   logic        wr_en;
   logic [15:0] wr_num;
   logic [7:0]  wr_val;
   logic [3:0]  level;
   logic        ovf;

   int          n_checks;
   int          n_fail;
   int          cycle;
   logic [23:0] strobe_q[$];
   int          strobe_ts[$];
   logic [7:0]  miso_byte;

   spi_register_controller #(
      .FIFO_DEPTH  (8),
      .SYNC_STAGES (2)
   ) dut (
      .i_Clock               (clk),
      .i_Reset               (rst),
      .i_SpiSck              (sck),
      .i_SpiCsN              (cs_n),
      .i_SpiMosi             (mosi),
      .o_SpiMiso             (miso),
      .i_WriteStall          (stall),
      .o_RegisterWriteEnable (wr_en),
      .o_RegisterWriteNumber (wr_num),
      .o_RegisterWriteValue  (wr_val),
      .o_FifoLevel           (level),
      .o_Overflow            (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every write strobe with the cycle it appeared in
   always @(negedge clk) begin
      cycle <= cycle + 1;
      if (wr_en === 1'b1) begin
         strobe_q.push_back({wr_num, wr_val});
         strobe_ts.push_back(cycle);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Mode-0 master: SCK = clk/8, MSB first, samples MISO just before each rise
   task automatic spi_xfer(input logic [47:0] data, input int nbits, output logic [7:0] mbyte);
      mbyte = 8'h00;
      cs_n  = 1'b0;
      clocks(4);
      for (int i = nbits - 1; i >= 0; i--) begin
         mosi = data[i];
         clocks(4);
         if ((nbits - 1 - i) < 8) mbyte = {mbyte[6:0], miso};
         sck = 1'b1;
         clocks(4);
         sck = 1'b0;
      end
      clocks(4);
      cs_n = 1'b1;
      mosi = 1'b0;
      clocks(6);
   endtask

   task automatic wait_strobes(input int n, input int budget);
      int k;
      k = 0;
      while ((strobe_q.size() < n) && (k < budget)) begin
         clocks(1);
         k++;
      end
      clocks(20);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cycle    = 0;
      rst      = 1'b1;
      sck      = 1'b0;
      cs_n     = 1'b1;
      mosi     = 1'b0;
      stall    = 1'b0;

      // Reset state
      clocks(3);
      check("rst_en",    32'(wr_en),  32'h0);
      check("rst_num",   32'(wr_num), 32'h0);
      check("rst_val",   32'(wr_val), 32'h0);
      check("rst_level", 32'(level),  32'h0);
      check("rst_ovf",   32'(ovf),    32'h0);
      check("rst_miso",  32'(miso),   32'h0);
      rst = 1'b0;
      clocks(5);

      // Single frame C4 25 7F
      spi_xfer(48'hC4257F, 24, miso_byte);
      wait_strobes(1, 100);
      check("single_count",  32'(strobe_q.size()), 32'd1);
      if (strobe_q.size() >= 1) check("single_data", 32'(strobe_q[0]), 32'hC4257F);
      check("single_level",  32'(level), 32'h0);
      check("single_status", 32'(miso_byte), 32'h20);
      strobe_q.delete();
      strobe_ts.delete();

      // Stalled writes then consecutive release
      stall = 1'b1;
      spi_xfer(48'hC00001, 24, miso_byte);
      spi_xfer(48'hC00102, 24, miso_byte);
      spi_xfer(48'h400003, 24, miso_byte);
      clocks(10);
      check("stall_count",  32'(strobe_q.size()), 32'd0);
      check("stall_level",  32'(level), 32'd3);
      check("stall_status", 32'(miso_byte), 32'h00);
      stall = 1'b0;
      wait_strobes(3, 100);
      check("drain3_count", 32'(strobe_q.size()), 32'd3);
      if (strobe_q.size() >= 3) begin
         check("drain3_0",   32'(strobe_q[0]), 32'hC00001);
         check("drain3_1",   32'(strobe_q[1]), 32'hC00102);
         check("drain3_2",   32'(strobe_q[2]), 32'h400003);
         check("drain3_gap1", 32'(strobe_ts[1] - strobe_ts[0]), 32'd1);
         check("drain3_gap2", 32'(strobe_ts[2] - strobe_ts[1]), 32'd1);
      end
      check("drain3_level", 32'(level), 32'd0);
      strobe_q.delete();
      strobe_ts.delete();

      // Partial frame (13 bits) is dropped, following frame stands
      spi_xfer(48'h1ABC, 13, miso_byte);
      spi_xfer(48'h800255, 24, miso_byte);
      wait_strobes(1, 100);
      check("partial_count", 32'(strobe_q.size()), 32'd1);
      if (strobe_q.size() >= 1) check("partial_data", 32'(strobe_q[0]), 32'h800255);
      check("partial_ovf", 32'(ovf), 32'd0);
      strobe_q.delete();
      strobe_ts.delete();

      // Extra data bytes after the header
      spi_xfer(48'hFFFE112233, 40, miso_byte);
`ifdef SPI_AUTO_INCREMENT_EN
      wait_strobes(3, 100);
      check("autoinc_count", 32'(strobe_q.size()), 32'd3);
      if (strobe_q.size() >= 3) begin
         check("autoinc_0", 32'(strobe_q[0]), 32'hFFFE11);
         check("autoinc_1", 32'(strobe_q[1]), 32'hFFFF22);
         check("autoinc_2", 32'(strobe_q[2]), 32'h000033);
      end
`else
      wait_strobes(1, 100);
      check("noinc_count", 32'(strobe_q.size()), 32'd1);
      if (strobe_q.size() >= 1) check("noinc_0", 32'(strobe_q[0]), 32'hFFFE11);
`endif
      strobe_q.delete();
      strobe_ts.delete();

      // Overflow: nine frames into an eight-deep stalled FIFO
      stall = 1'b1;
      for (int i = 0; i < 9; i++) begin
         spi_xfer({24'h0, 16'h1000 + 16'(i), 8'(i + 1)}, 24, miso_byte);
      end
      clocks(5);
      check("ovf_level", 32'(level), 32'd8);
      check("ovf_flag",  32'(ovf),   32'd1);
      spi_xfer(48'h1FFFAA, 24, miso_byte);
      check("ovf_status", 32'(miso_byte), 32'hC0);
      stall = 1'b0;
      wait_strobes(8, 200);
      check("ovf_drain_count", 32'(strobe_q.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (strobe_q.size() > i)
            check("ovf_drain_data", 32'(strobe_q[i]), 32'({16'h1000 + 16'(i), 8'(i + 1)}));
      end
      check("ovf_sticky", 32'(ovf), 32'd1);
      check("ovf_level0", 32'(level), 32'd0);
      strobe_q.delete();
      strobe_ts.delete();

      // Asynchronous reset in the middle of a frame with four entries queued
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         spi_xfer({24'h0, 16'h2000 + 16'(i), 8'h5A}, 24, miso_byte);
      end
      clocks(5);
      check("mid_level_pre", 32'(level), 32'd4);
      cs_n = 1'b0;
      clocks(4);
      for (int i = 0; i < 5; i++) begin
         mosi = 1'b1;
         clocks(4);
         sck = 1'b1;
         clocks(4);
         sck = 1'b0;
      end
      #2 rst = 1'b1;
      #1;
      check("mid_rst_level", 32'(level),  32'd0);
      check("mid_rst_ovf",   32'(ovf),    32'd0);
      check("mid_rst_num",   32'(wr_num), 32'd0);
      check("mid_rst_val",   32'(wr_val), 32'd0);
      check("mid_rst_en",    32'(wr_en),  32'd0);
      check("mid_rst_miso",  32'(miso),   32'd0);
      @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'b0;
      clocks(4);
      rst   = 1'b0;
      stall = 1'b0;
      clocks(10);
      strobe_q.delete();
      strobe_ts.delete();
      spi_xfer(48'h123456, 24, miso_byte);
      wait_strobes(1, 100);
      check("post_rst_count", 32'(strobe_q.size()), 32'd1);
      if (strobe_q.size() >= 1) check("post_rst_data", 32'(strobe_q[0]), 32'h123456);
      check("post_rst_level", 32'(level), 32'd0);
      check("post_rst_ovf",   32'(ovf),   32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
